// File: rtl/alu_share_arbiter_pkg.sv
// Shared types for the ALU sharing arbiter: ALU control codes, request and
// response records, and the branch-class decode.
package alu_share_arbiter_pkg;

  typedef enum logic [4:0] {
    ALU_ADD   = 5'h00,
    ALU_SUB   = 5'h01,
    ALU_XOR   = 5'h02,
    ALU_OR    = 5'h03,
    ALU_AND   = 5'h04,
    ALU_SLL   = 5'h05,
    ALU_SRL   = 5'h06,
    ALU_SRA   = 5'h07,
    ALU_SLT   = 5'h08,
    ALU_SLTU  = 5'h09,
    ALU_BEQ   = 5'h0A,
    ALU_BNE   = 5'h0B,
    ALU_BLT   = 5'h0C,
    ALU_BGE   = 5'h0D,
    ALU_BLTU  = 5'h0E,
    ALU_BGEU  = 5'h0F,
    ALU_LUI   = 5'h10,
    ALU_AUIPC = 5'h11,
    ALU_JAL   = 5'h12,
    ALU_JALR  = 5'h13
  } alu_op_e;

  typedef struct packed {
    logic [31:0] op1;
    logic [31:0] op2;
    logic [4:0]  ctrl;
    logic [31:0] pc;
  } alu_req_t;

  typedef struct packed {
    logic        id;
    logic [31:0] result;
    logic        redirect;
    logic [31:0] target;
  } alu_resp_t;

  function automatic logic is_branch(input logic [4:0] ctrl);
    return (ctrl >= ALU_BEQ) && (ctrl <= ALU_BGEU);
  endfunction

endpackage

// File: rtl/alu_share_arbiter_rr_arb2.sv
// Two-way round-robin grant; the pointer names the requester preferred when
// both are valid and flips to the other side after every accepted transfer.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] valid,
  input  logic       advance,
  input  logic       advance_id,
  output logic [1:0] grant
);

  logic ptr_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_reg <= 1'b0;
    end else if (advance) begin
      ptr_reg <= ~advance_id;
    end
  end

  always_comb begin
    grant = 2'b00;
    case (valid)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = ptr_reg ? 2'b10 : 2'b01;
      default: grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one combinational ALU between the EX stage (id 0) and the address
// unit (id 1), registering the ALU outcome into a single tagged response slot.
module alu_share_arbiter
  import alu_share_arbiter_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [1:0][31:0] req_op1,
  input  logic [1:0][31:0] req_op2,
  input  logic [1:0][4:0]  req_ctrl,
  input  logic [1:0][31:0] req_pc,
  output logic [31:0]      alu_op1,
  output logic [31:0]      alu_op2,
  output logic [31:0]      alu_pc,
  output logic [4:0]       alu_ctrl,
  input  logic [31:0]      alu_result,
  input  logic             alu_branch_taken,
  input  logic             alu_jal_jump,
  input  logic             alu_jalr_jump,
  input  logic [31:0]      alu_branch_target,
  input  logic [31:0]      alu_jal_target,
  input  logic [31:0]      alu_jalr_target,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic             resp_id,
  output logic [31:0]      resp_result,
  output logic             resp_redirect,
  output logic [31:0]      resp_target,
  output logic [CNT_W-1:0] grant_cnt0,
  output logic [CNT_W-1:0] grant_cnt1
);

  alu_req_t   req [2];
  alu_req_t   sel_req;
  alu_resp_t  resp_reg;
  alu_resp_t  resp_next;
  logic       resp_valid_reg;
  logic [1:0] grant;
  logic [1:0] take;
  logic       accept_ok;
  logic       xfer;
  logic       xfer_id;

  for (genvar gi = 0; gi < 2; gi++) begin : g_req
    assign req[gi].op1  = req_op1[gi];
    assign req[gi].op2  = req_op2[gi];
    assign req[gi].ctrl = req_ctrl[gi];
    assign req[gi].pc   = req_pc[gi];
  end

  rr_arb2 u_arb (
    .clk        (clk),
    .rst        (rst),
    .valid      (req_valid),
    .advance    (xfer),
    .advance_id (xfer_id),
    .grant      (grant)
  );

  // The slot can take a new result if it is empty or being drained this cycle.
  assign accept_ok = ~resp_valid_reg | resp_ready;
  assign req_ready = rst ? 2'b00 : (grant & {2{accept_ok}});
  assign take      = req_valid & req_ready;
  assign xfer      = |take;
  assign xfer_id   = take[1];

  // With no grant the mux falls back to requester 0.
  assign sel_req  = grant[1] ? req[1] : req[0];
  assign alu_op1  = sel_req.op1;
  assign alu_op2  = sel_req.op2;
  assign alu_pc   = sel_req.pc;
  assign alu_ctrl = sel_req.ctrl;

  always_comb begin
    resp_next          = '0;
    resp_next.id       = xfer_id;
    resp_next.result   = alu_result;
    resp_next.redirect = alu_branch_taken | alu_jal_jump | alu_jalr_jump;
    if (is_branch(sel_req.ctrl)) begin
      resp_next.target = alu_branch_target;
    end else if (sel_req.ctrl == ALU_JAL) begin
      resp_next.target = alu_jal_target;
    end else if (sel_req.ctrl == ALU_JALR) begin
      resp_next.target = alu_jalr_target;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      resp_valid_reg <= 1'b0;
      resp_reg       <= '0;
    end else if (xfer) begin
      resp_valid_reg <= 1'b1;
      resp_reg       <= resp_next;
    end else if (resp_ready) begin
      resp_valid_reg <= 1'b0;
    end
  end

  assign resp_valid    = resp_valid_reg;
  assign resp_id       = resp_reg.id;
  assign resp_result   = resp_reg.result;
  assign resp_redirect = resp_reg.redirect;
  assign resp_target   = resp_reg.target;

  for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
    logic [CNT_W-1:0] cnt_reg;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        cnt_reg <= '0;
      end else if (take[gi] && (cnt_reg != '1)) begin
        cnt_reg <= cnt_reg + CNT_W'(1);
      end
    end
  end

  assign grant_cnt0 = g_cnt[0].cnt_reg;
  assign grant_cnt1 = g_cnt[1].cnt_reg;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter with a small behavioural RV32I ALU
// closing the loop between the arbiter's alu_* outputs and ALU inputs.
module tb_alu_share_arbiter;

  logic             clk;
  logic             rst;
  logic [1:0]       req_valid;
  logic [1:0]       req_ready;
  logic [1:0][31:0] req_op1;
  logic [1:0][31:0] req_op2;
  logic [1:0][4:0]  req_ctrl;
  logic [1:0][31:0] req_pc;
  logic [31:0]      alu_op1, alu_op2, alu_pc;
  logic [4:0]       alu_ctrl;
  logic [31:0]      alu_result;
  logic             alu_branch_taken, alu_jal_jump, alu_jalr_jump;
  logic [31:0]      alu_branch_target, alu_jal_target, alu_jalr_target;
  logic             resp_valid, resp_ready, resp_id, resp_redirect;
  logic [31:0]      resp_result, resp_target;
  logic [15:0]      grant_cnt0, grant_cnt1;

  logic [1:0]       s_req_ready;
  logic [31:0]      s_alu_op1, s_alu_op2, s_alu_pc;
  logic [4:0]       s_alu_ctrl;
  logic             s_resp_valid, s_resp_id, s_resp_redirect;
  logic [31:0]      s_resp_result, s_resp_target;
  logic [1:0]       s_cnt0, s_cnt1;

  int checks = 0;
  int errors = 0;

  alu_share_arbiter #(.CNT_W(16)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_op1(req_op1), .req_op2(req_op2), .req_ctrl(req_ctrl), .req_pc(req_pc),
    .alu_op1(alu_op1), .alu_op2(alu_op2), .alu_pc(alu_pc), .alu_ctrl(alu_ctrl),
    .alu_result(alu_result), .alu_branch_taken(alu_branch_taken),
    .alu_jal_jump(alu_jal_jump), .alu_jalr_jump(alu_jalr_jump),
    .alu_branch_target(alu_branch_target), .alu_jal_target(alu_jal_target),
    .alu_jalr_target(alu_jalr_target), .resp_valid(resp_valid),
    .resp_ready(resp_ready), .resp_id(resp_id), .resp_result(resp_result),
    .resp_redirect(resp_redirect), .resp_target(resp_target),
    .grant_cnt0(grant_cnt0), .grant_cnt1(grant_cnt1)
  );

  // Narrow-counter instance sees identical traffic; only its counters are checked.
  alu_share_arbiter #(.CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(s_req_ready),
    .req_op1(req_op1), .req_op2(req_op2), .req_ctrl(req_ctrl), .req_pc(req_pc),
    .alu_op1(s_alu_op1), .alu_op2(s_alu_op2), .alu_pc(s_alu_pc), .alu_ctrl(s_alu_ctrl),
    .alu_result(alu_result), .alu_branch_taken(alu_branch_taken),
    .alu_jal_jump(alu_jal_jump), .alu_jalr_jump(alu_jalr_jump),
    .alu_branch_target(alu_branch_target), .alu_jal_target(alu_jal_target),
    .alu_jalr_target(alu_jalr_target), .resp_valid(s_resp_valid),
    .resp_ready(resp_ready), .resp_id(s_resp_id), .resp_result(s_resp_result),
    .resp_redirect(s_resp_redirect), .resp_target(s_resp_target),
    .grant_cnt0(s_cnt0), .grant_cnt1(s_cnt1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always_comb begin
    alu_result        = 32'h0;
    alu_branch_taken  = 1'b0;
    alu_jal_jump      = 1'b0;
    alu_jalr_jump     = 1'b0;
    alu_branch_target = alu_pc + alu_op2;
    alu_jal_target    = alu_pc + alu_op2;
    alu_jalr_target   = (alu_op1 + alu_op2) & 32'hFFFF_FFFE;
    case (alu_ctrl)
      5'h00: alu_result = alu_op1 + alu_op2;
      5'h01: alu_result = alu_op1 - alu_op2;
      5'h02: alu_result = alu_op1 ^ alu_op2;
      5'h03: alu_result = alu_op1 | alu_op2;
      5'h04: alu_result = alu_op1 & alu_op2;
      5'h05: alu_result = alu_op1 << alu_op2[4:0];
      5'h06: alu_result = alu_op1 >> alu_op2[4:0];
      5'h07: alu_result = $unsigned($signed(alu_op1) >>> alu_op2[4:0]);
      5'h08: alu_result = {31'h0, $signed(alu_op1) < $signed(alu_op2)};
      5'h09: alu_result = {31'h0, alu_op1 < alu_op2};
      5'h0A: alu_branch_taken = (alu_op1 == alu_op2);
      5'h0B: alu_branch_taken = (alu_op1 != alu_op2);
      5'h0C: alu_branch_taken = ($signed(alu_op1) < $signed(alu_op2));
      5'h0D: alu_branch_taken = ($signed(alu_op1) >= $signed(alu_op2));
      5'h0E: alu_branch_taken = (alu_op1 < alu_op2);
      5'h0F: alu_branch_taken = (alu_op1 >= alu_op2);
      5'h10: alu_result = alu_op2;
      5'h11: alu_result = alu_pc + alu_op2;
      5'h12: begin alu_result = alu_pc + 32'd4; alu_jal_jump = 1'b1; end
      5'h13: begin alu_result = alu_pc + 32'd4; alu_jalr_jump = 1'b1; end
      default: alu_result = 32'h0;
    endcase
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [1:0]  valid;
    logic        rr;
    logic [4:0]  c0;
    logic [31:0] a0, b0, p0;
    logic [4:0]  c1;
    logic [31:0] a1, b1, p1;
    logic [1:0]  ready;
    logic        rv;
    logic        id;
    logic [31:0] res;
    logic        redir;
    logic [31:0] tgt;
    int          cnt0, cnt1;
  } vec_t;

  function automatic vec_t mk(
    input logic [1:0] valid, input logic rr,
    input logic [4:0] c0, input logic [31:0] a0, b0, p0,
    input logic [4:0] c1, input logic [31:0] a1, b1, p1,
    input logic [1:0] ready, input logic rv, input logic id,
    input logic [31:0] res, input logic redir, input logic [31:0] tgt,
    input int cnt0, input int cnt1);
    vec_t v;
    v.valid = valid; v.rr = rr;
    v.c0 = c0; v.a0 = a0; v.b0 = b0; v.p0 = p0;
    v.c1 = c1; v.a1 = a1; v.b1 = b1; v.p1 = p1;
    v.ready = ready; v.rv = rv; v.id = id; v.res = res;
    v.redir = redir; v.tgt = tgt; v.cnt0 = cnt0; v.cnt1 = cnt1;
    return v;
  endfunction

  task automatic drive(input logic [1:0] valid, input logic rr,
                       input logic [4:0] c0, input logic [31:0] a0, b0, p0,
                       input logic [4:0] c1, input logic [31:0] a1, b1, p1);
    req_valid = valid; resp_ready = rr;
    req_ctrl[0] = c0; req_op1[0] = a0; req_op2[0] = b0; req_pc[0] = p0;
    req_ctrl[1] = c1; req_op1[1] = a1; req_op2[1] = b1; req_pc[1] = p1;
  endtask

  task automatic chk_resp(input string tag, input logic rv, input logic id,
                          input logic [31:0] res, input logic redir, input logic [31:0] tgt);
    chk({tag, ".resp_valid"}, {31'h0, resp_valid}, {31'h0, rv});
    chk({tag, ".resp_id"}, {31'h0, resp_id}, {31'h0, id});
    chk({tag, ".resp_result"}, resp_result, res);
    chk({tag, ".resp_redirect"}, {31'h0, resp_redirect}, {31'h0, redir});
    chk({tag, ".resp_target"}, resp_target, tgt);
  endtask

  vec_t vecs[12];
  logic [4:0] exp_ctrl;
  logic [1:0] sat_exp [5];

  initial begin
    // ptr starts at 0; each row is one cycle, expectations are the state after the edge.
    vecs[0]  = mk(2'b11, 1, 5'h01, 10, 3, 0,  5'h02, 32'hF0, 32'h0F, 0,  2'b01, 1, 0, 7, 0, 0, 1, 0);
    vecs[1]  = mk(2'b11, 1, 5'h01, 10, 3, 0,  5'h02, 32'hF0, 32'h0F, 0,  2'b10, 1, 1, 32'hFF, 0, 0, 1, 1);
    vecs[2]  = mk(2'b11, 1, 5'h01, 10, 3, 0,  5'h02, 32'hF0, 32'h0F, 0,  2'b01, 1, 0, 7, 0, 0, 2, 1);
    vecs[3]  = mk(2'b11, 1, 5'h01, 10, 3, 0,  5'h02, 32'hF0, 32'h0F, 0,  2'b10, 1, 1, 32'hFF, 0, 0, 2, 2);
    vecs[4]  = mk(2'b01, 1, 5'h00, 5, 7, 0,   5'h02, 32'hF0, 32'h0F, 0,  2'b01, 1, 0, 12, 0, 0, 3, 2);
    vecs[5]  = mk(2'b01, 1, 5'h0A, 32'h10, 32'h10, 32'h100, 5'h00, 0, 0, 0, 2'b01, 1, 0, 0, 1, 32'h110, 4, 2);
    vecs[6]  = mk(2'b01, 1, 5'h13, 32'h2001, 4, 32'h40, 5'h00, 0, 0, 0, 2'b01, 1, 0, 32'h44, 1, 32'h2004, 5, 2);
    vecs[7]  = mk(2'b01, 1, 5'h0B, 32'h10, 32'h10, 32'h100, 5'h00, 0, 0, 0, 2'b01, 1, 0, 0, 0, 32'h110, 6, 2);
    vecs[8]  = mk(2'b10, 1, 5'h00, 0, 0, 0,   5'h15, 1, 2, 32'h80, 2'b10, 1, 1, 0, 0, 0, 6, 3);
    vecs[9]  = mk(2'b10, 1, 5'h00, 0, 0, 0,   5'h12, 0, 32'h20, 32'h200, 2'b10, 1, 1, 32'h204, 1, 32'h220, 6, 4);
    vecs[10] = mk(2'b00, 1, 5'h00, 0, 0, 0,   5'h12, 0, 32'h20, 32'h200, 2'b00, 0, 1, 32'h204, 1, 32'h220, 6, 4);
    vecs[11] = mk(2'b11, 1, 5'h00, 5, 7, 0,   5'h02, 32'hF0, 32'h0F, 0,  2'b01, 1, 0, 12, 0, 0, 7, 4);
    sat_exp[0] = 2'd1; sat_exp[1] = 2'd2; sat_exp[2] = 2'd3; sat_exp[3] = 2'd3; sat_exp[4] = 2'd3;

    rst = 1'b1;
    drive(2'b11, 1'b1, 5'h00, 0, 0, 0, 5'h00, 0, 0, 0);
    #1;
    chk("reset.req_ready", {30'h0, req_ready}, 32'h0);
    chk_resp("reset", 0, 0, 0, 0, 0);
    chk("reset.cnt0", {16'h0, grant_cnt0}, 32'h0);
    chk("reset.cnt1", {16'h0, grant_cnt1}, 32'h0);
    drive(2'b00, 1'b1, 5'h00, 0, 0, 0, 5'h00, 0, 0, 0);
    #11 rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 12; i++) begin
      drive(vecs[i].valid, vecs[i].rr, vecs[i].c0, vecs[i].a0, vecs[i].b0, vecs[i].p0,
            vecs[i].c1, vecs[i].a1, vecs[i].b1, vecs[i].p1);
      #1;
      exp_ctrl = vecs[i].ready[1] ? vecs[i].c1 : vecs[i].c0;
      chk($sformatf("v%0d.req_ready", i), {30'h0, req_ready}, {30'h0, vecs[i].ready});
      chk($sformatf("v%0d.alu_ctrl", i), {27'h0, alu_ctrl}, {27'h0, exp_ctrl});
      @(posedge clk); #1;
      chk_resp($sformatf("v%0d", i), vecs[i].rv, vecs[i].id, vecs[i].res, vecs[i].redir, vecs[i].tgt);
      chk($sformatf("v%0d.cnt0", i), {16'h0, grant_cnt0}, vecs[i].cnt0);
      chk($sformatf("v%0d.cnt1", i), {16'h0, grant_cnt1}, vecs[i].cnt1);
      $display("vec %0d valid=%b ready=%b -> rv=%b id=%0d res=%0h redir=%b tgt=%0h cnt=%0d/%0d",
               i, req_valid, req_ready, resp_valid, resp_id, resp_result, resp_redirect,
               resp_target, grant_cnt0, grant_cnt1);
    end

    // Backpressure: slot holds id0/12 while req1 waits.
    drive(2'b10, 1'b0, 5'h00, 5, 7, 0, 5'h02, 32'hF0, 32'h0F, 0);
    for (int k = 0; k < 3; k++) begin
      #1;
      chk($sformatf("bp%0d.req_ready", k), {30'h0, req_ready}, 32'h0);
      @(posedge clk); #1;
      chk_resp($sformatf("bp%0d", k), 1, 0, 12, 0, 0);
      chk($sformatf("bp%0d.cnt1", k), {16'h0, grant_cnt1}, 32'd4);
      $display("stall %0d ready=%b rv=%b id=%0d res=%0h", k, req_ready, resp_valid, resp_id, resp_result);
      #(-1 + 1);
    end
    resp_ready = 1'b1;
    #1;
    chk("bp_release.req_ready", {30'h0, req_ready}, 32'h2);
    @(posedge clk); #1;
    chk_resp("bp_release", 1, 1, 32'hFF, 0, 0);
    chk("bp_release.cnt1", {16'h0, grant_cnt1}, 32'd5);
    $display("drain+refill rv=%b id=%0d res=%0h cnt1=%0d", resp_valid, resp_id, resp_result, grant_cnt1);

    // Async reset while a response is pending and req1 is stalled.
    resp_ready = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("mid_rst.req_ready", {30'h0, req_ready}, 32'h0);
    chk_resp("mid_rst", 0, 0, 0, 0, 0);
    chk("mid_rst.cnt0", {16'h0, grant_cnt0}, 32'h0);
    chk("mid_rst.cnt1", {16'h0, grant_cnt1}, 32'h0);
    $display("async reset rv=%b ready=%b cnt=%0d/%0d", resp_valid, req_ready, grant_cnt0, grant_cnt1);
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    chk("post_rst.req_ready", {30'h0, req_ready}, 32'h2);
    resp_ready = 1'b1;
    @(posedge clk); #1;
    chk_resp("post_rst", 1, 1, 32'hFF, 0, 0);
    chk("post_rst.cnt1", {16'h0, grant_cnt1}, 32'd1);
    $display("post reset grant rv=%b id=%0d res=%0h", resp_valid, resp_id, resp_result);

    // Five req0 grants: 16-bit counter counts on, 2-bit counter saturates at 3.
    drive(2'b01, 1'b1, 5'h00, 5, 7, 0, 5'h02, 32'hF0, 32'h0F, 0);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      chk($sformatf("sat%0d.resp_result", k), resp_result, 32'd12);
      chk($sformatf("sat%0d.resp_id", k), {31'h0, resp_id}, 32'h0);
      chk($sformatf("sat%0d.cnt0_w16", k), {16'h0, grant_cnt0}, k + 1);
      chk($sformatf("sat%0d.cnt0_w2", k), {30'h0, s_cnt0}, {30'h0, sat_exp[k]});
      $display("sat %0d cnt0=%0d cnt0_w2=%0d", k, grant_cnt0, s_cnt0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
- Shares one combinational RV32I ALU between two requesters: requester 0 is the core EX stage; requester 1 is the address/auxiliary unit.
- Arbitrates round-robin with valid/ready handshakes and drives the shared ALU's inputs.
- Captures the ALU outputs into a single registered response stage tagged with the requester id.
- Sits between issue logic and the ALU instance; also keeps saturating per-requester grant counters for performance monitoring.

Parameters:
- CNT_W, 16, width of each saturating grant counter.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  2  per-requester request valid.
- req_ready  out  2  per-requester accept; a transfer occurs when valid & ready.
- req_op1  in  2x32  per-requester operand 1.
- req_op2  in  2x32  per-requester operand 2 / immediate.
- req_ctrl  in  2x5  per-requester ALU control code.
- req_pc  in  2x32  per-requester PC.
- alu_op1, alu_op2, alu_pc  out  32 each  drive the shared ALU.
- alu_ctrl  out  5  drives the shared ALU.
- alu_result  in  32  from the ALU.
- alu_branch_taken, alu_jal_jump, alu_jalr_jump  in  1 each  from the ALU.
- alu_branch_target, alu_jal_target, alu_jalr_target  in  32 each  from the ALU.
- resp_valid  out  1  response valid.
- resp_ready  in  1  response consumer ready.
- resp_id  out  1  requester that owns the response.
- resp_result  out  32  registered alu_result.
- resp_redirect  out  1  registered (branch_taken | jal_jump | jalr_jump).
- resp_target  out  32  registered selected target.
- grant_cnt0, grant_cnt1  out  CNT_W each  saturating accepted-request counts.

Behaviour:
- Reset (async, active-high): resp_valid=0; resp_id=0; resp_result=0; resp_redirect=0; resp_target=0; both counters=0; priority pointer=0 (requester 0 preferred). req_ready=0 while rst is asserted.
- accept_ok = ~resp_valid | resp_ready.
- Grant (combinational):
  - If only one requester is valid, grant it.
  - If both are valid, grant the pointer's requester.
  - req_ready[i] = grant[i] & accept_ok. At most one req_ready bit is high.
- ALU drive:
  - alu_* = granted requester's fields.
  - When neither requester is valid, alu_* = requester 0's fields (don't-care, but deterministic).
- On a transfer from requester i:
  - Response register loads at the next clk edge: resp_valid=1, resp_id=i, resp_result=alu_result.
  - resp_redirect = alu_branch_taken | alu_jal_jump | alu_jalr_jump.
  - resp_target: branch ctrl codes 0x0A-0x0F -> alu_branch_target; 0x12 -> alu_jal_target; 0x13 -> alu_jalr_target; otherwise 0.
  - Pointer <= 1-i.
  - grant_cnt_i increments, saturating at all-ones.
- Latency: 1 cycle from transfer to resp_valid. Throughput: 1 per cycle while resp_ready=1.
- Backpressure: resp_valid=1 and resp_ready=0 -> all response fields hold; req_ready=0; pointer and counters hold.
- Drain and refill in the same cycle: resp_valid & resp_ready together with a new transfer -> register reloads, resp_valid stays 1.
- Drain only: resp_valid & resp_ready with no transfer -> resp_valid <= 0; data fields hold.
- Requester rules: a requester with valid=1 and ready=0 must hold valid and all fields stable. The arbiter must not drop that request.
- Starvation bound: with both requesters continuously valid, grants alternate strictly. Each requester waits at most one transfer.
- Undefined ctrl codes (>0x13): passed to the ALU unchanged; the result is whatever the ALU returns (0). resp_redirect=0, resp_target=0.
- Reset mid-operation: a pending response is discarded and nothing is replayed. Requesters must reissue.

Decomposition:
- alu_pkg (shared):
  - alu_op_e, 5-bit enum: ADD=0x00 ... SLTU=0x09, BEQ=0x0A ... BGEU=0x0F, LUI=0x10, AUIPC=0x11, JAL=0x12, JALR=0x13.
  - is_branch() function.
  - alu_req_t struct {op1, op2, ctrl, pc}.
  - alu_resp_t struct {id, result, redirect, target}.
- Sub-module rr_arb2: 2-way round-robin grant plus pointer register. Inputs: valid[1:0], advance, advance_id. Output: grant[1:0].

Test Plan:
- Reset, then req0 only: ADD op1=5, op2=7, resp_ready=1 -> next cycle resp_valid=1, id=0, result=12, redirect=0, target=0; grant_cnt0=1.
- Both valid every cycle after reset, resp_ready=1: req0 SUB 10-3, req1 XOR 0xF0^0x0F -> responses id 0 (7), id 1 (0xFF), id 0, id 1, ... strictly alternating.
- Backpressure: resp_ready=0 for 3 cycles with req1 valid -> resp fields stable, req_ready=00. Raising resp_ready -> old response drains and the req1 transfer occurs in the same cycle; its response appears the next cycle.
- Control flow:
  - BEQ op1=op2=0x10, pc=0x100 -> redirect=1, target=0x110.
  - JALR op1=0x2001, op2=4, pc=0x40 -> redirect=1, target=0x2004, result=0x44.
  - BNE with equal operands -> redirect=0, target still the branch target.
- Assert rst while resp_valid=1 and req1 is stalled -> all outputs are 0 immediately (async). After release, req1 is granted the first cycle it is valid.
- CNT_W=2, 5 grants to req0 -> grant_cnt0 reads 1, 2, 3, 3, 3.
